// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI command sequencer.
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_LOAD,
    ST_XFER,
    ST_CS_HOLD,
    ST_CS_GAP
  } seq_state_t;

  // Clocked out on MOSI for every payload slot of a read transaction.
  localparam logic [7:0] SPI_NOP_BYTE = 8'hFF;

  // Byte-counter width: holds 1 command byte plus max_payload data bytes.
  function automatic int unsigned count_width(input int unsigned max_payload);
    return $clog2(max_payload + 2);
  endfunction

endpackage

// File: rtl/spi_seq_delay.sv
// Loadable down-counter used for chip-select setup, hold and idle gaps.
module spi_seq_delay #(
  parameter int W = 4
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [W-1:0] i_Count,
  output logic         o_Zero
);

  logic [W-1:0] count;

  // Load on request, otherwise count down and stop at zero.
  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      count <= '0;
    end else if (i_Load) begin
      count <= i_Count;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign o_Zero = (count == '0);

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Multi-byte SPI command sequencer (command byte + 0..MAX_PAYLOAD data bytes)
// on top of a byte-level SPI transceiver. Owns chip-select timing.
// Optional feature: define SPI_SEQ_TIMEOUT_EN to abort a stalled transaction
// after TIMEOUT_CLKS cycles in LOAD/XFER (o_Abort flags it with o_Done).
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter int MAX_PAYLOAD   = 32,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_IDLE_CLKS  = 8,
  parameter int TIMEOUT_CLKS  = 1024
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Start,
  input  logic [7:0] i_Cmd,
  input  logic [5:0] i_Len,
  input  logic       i_Rd,
  input  logic [7:0] i_TX_Data,
  input  logic       i_TX_Valid,
  output logic       o_TX_Ready,
  output logic [7:0] o_RX_Data,
  output logic       o_RX_Valid,
  output logic [7:0] o_Status,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Abort,
  output logic [7:0] o_M_TX_Byte,
  output logic       o_M_TX_DV,
  input  logic       i_M_TX_Ready,
  input  logic       i_M_RX_DV,
  input  logic [7:0] i_M_RX_Byte,
  output logic       o_SPI_CS_n
);

  localparam int CW = count_width(MAX_PAYLOAD);
  localparam int DLY_MAX_A = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int DLY_MAX   = (DLY_MAX_A > CS_IDLE_CLKS) ? DLY_MAX_A : CS_IDLE_CLKS;
  localparam int DW = $clog2(DLY_MAX + 1);

  seq_state_t    state, state_next;
  logic [7:0]    cmd_q;
  logic          rd_q;
  logic [CW-1:0] remaining;
  logic [CW-1:0] len_clamped;
  logic          first_tx, first_rx;
  logic          dly_load, dly_zero;
  logic [DW-1:0] dly_count;
  logic          accept, issue, rx_take, finish;
  logic          timeout_hit;

  assign len_clamped = (int'(i_Len) > MAX_PAYLOAD) ? CW'(MAX_PAYLOAD) : CW'(i_Len);
  assign o_Busy      = (state != ST_IDLE);
  assign o_TX_Ready  = (state == ST_LOAD) && i_M_TX_Ready && !rd_q && !first_tx && !timeout_hit;

  spi_seq_delay #(.W(DW)) u_delay (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Load  (dly_load),
    .i_Count (dly_count),
    .o_Zero  (dly_zero)
  );

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state logic and one-cycle control strobes.
  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_next = state;
    dly_load   = 1'b0;
    dly_count  = '0;
    accept     = 1'b0;
    issue      = 1'b0;
    rx_take    = 1'b0;
    finish     = 1'b0;
    unique case (state)
      ST_IDLE: if (i_Start) begin
        accept     = 1'b1;
        dly_load   = 1'b1;
        dly_count  = DW'(CS_SETUP_CLKS);
        state_next = ST_CS_SETUP;
      end
      ST_CS_SETUP: if (dly_zero) state_next = ST_LOAD;
      ST_LOAD: if (i_M_TX_Ready && (first_tx || rd_q || i_TX_Valid)) begin
        issue      = 1'b1;
        state_next = ST_XFER;
      end
      ST_XFER: if (i_M_RX_DV) begin
        rx_take = 1'b1;
        if (remaining == CW'(1)) begin
          dly_load   = 1'b1;
          dly_count  = DW'(CS_HOLD_CLKS);
          state_next = ST_CS_HOLD;
        end else begin
          state_next = ST_LOAD;
        end
      end
      ST_CS_HOLD: if (dly_zero) begin
        finish     = 1'b1;
        dly_load   = 1'b1;
        dly_count  = DW'(CS_IDLE_CLKS);
        state_next = ST_CS_GAP;
      end
      ST_CS_GAP: if (dly_zero) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    // A stalled transfer is cut short; any late RX byte is dropped.
    if (timeout_hit) begin
      issue      = 1'b0;
      rx_take    = 1'b0;
      dly_load   = 1'b1;
      dly_count  = DW'(CS_HOLD_CLKS);
      state_next = ST_CS_HOLD;
    end
  end

  // Transaction datapath: latch request, drive transceiver, forward RX bytes, chip select.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cmd_q       <= 8'h00;
      rd_q        <= 1'b0;
      remaining   <= '0;
      first_tx    <= 1'b0;
      first_rx    <= 1'b0;
      o_SPI_CS_n  <= 1'b1;
      o_Done      <= 1'b0;
      o_RX_Valid  <= 1'b0;
      o_RX_Data   <= 8'h00;
      o_Status    <= 8'h00;
      o_M_TX_DV   <= 1'b0;
      o_M_TX_Byte <= 8'h00;
    end else begin
      o_Done     <= 1'b0;
      o_RX_Valid <= 1'b0;
      o_M_TX_DV  <= 1'b0;
      if (accept) begin
        cmd_q      <= i_Cmd;
        rd_q       <= i_Rd;
        remaining  <= len_clamped + CW'(1);
        first_tx   <= 1'b1;
        first_rx   <= 1'b1;
        o_SPI_CS_n <= 1'b0;
      end
      if (issue) begin
        o_M_TX_DV   <= 1'b1;
        o_M_TX_Byte <= first_tx ? cmd_q : (rd_q ? SPI_NOP_BYTE : i_TX_Data);
        first_tx    <= 1'b0;
      end
      if (rx_take) begin
        o_RX_Data  <= i_M_RX_Byte;
        o_RX_Valid <= 1'b1;
        remaining  <= remaining - CW'(1);
        first_rx   <= 1'b0;
        if (first_rx) o_Status <= i_M_RX_Byte;
      end
      if (finish) begin
        o_SPI_CS_n <= 1'b1;
        o_Done     <= 1'b1;
      end
    end
  end

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  logic [TW-1:0] to_cnt;
  logic          abort_q;
  logic          in_wait;

  assign in_wait     = (state == ST_LOAD) || (state == ST_XFER);
  assign timeout_hit = in_wait && (to_cnt == TW'(TIMEOUT_CLKS - 1));

  // Stall timer: runs in LOAD/XFER, restarts on every state change.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || !in_wait || (state_next != state)) to_cnt <= '0;
    else                                            to_cnt <= to_cnt + TW'(1);
  end

  // Abort flag remembered until the end-of-transaction pulse.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      abort_q <= 1'b0;
      o_Abort <= 1'b0;
    end else begin
      o_Abort <= finish && abort_q;
      if (accept)           abort_q <= 1'b0;
      else if (timeout_hit) abort_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign o_Abort     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a behavioural byte-transceiver
// model (MISO bytes come from slave_q, MOSI bytes are recorded in mosi_q).
module tb_spi_cmd_sequencer;

  typedef logic [7:0] byte_q_t[$];

  logic       i_Clk, i_Rst;
  logic       i_Start, i_Rd, i_TX_Valid;
  logic [7:0] i_Cmd, i_TX_Data;
  logic [5:0] i_Len;
  logic       o_TX_Ready, o_RX_Valid, o_Busy, o_Done, o_Abort, o_M_TX_DV, o_SPI_CS_n;
  logic [7:0] o_RX_Data, o_Status, o_M_TX_Byte;
  logic       m_ready, m_rx_dv;
  logic [7:0] m_rx_byte;

  spi_cmd_sequencer dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Start(i_Start), .i_Cmd(i_Cmd), .i_Len(i_Len),
    .i_Rd(i_Rd), .i_TX_Data(i_TX_Data), .i_TX_Valid(i_TX_Valid), .o_TX_Ready(o_TX_Ready),
    .o_RX_Data(o_RX_Data), .o_RX_Valid(o_RX_Valid), .o_Status(o_Status), .o_Busy(o_Busy),
    .o_Done(o_Done), .o_Abort(o_Abort), .o_M_TX_Byte(o_M_TX_Byte), .o_M_TX_DV(o_M_TX_DV),
    .i_M_TX_Ready(m_ready), .i_M_RX_DV(m_rx_dv), .i_M_RX_Byte(m_rx_byte), .o_SPI_CS_n(o_SPI_CS_n)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;
  byte_q_t mosi_q, slave_q, rx_q, tx_q, exp_q;
  logic tx_stall = 1'b0;
  int done_cnt = 0, abort_cnt = 0, dv_cs_bad = 0;
  int hi_streak = 0, lo_streak = 0, min_gap = 9999, min_setup = 9999;
  logic gap_arm = 1'b0, setup_open = 1'b0, done_cs = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag, input byte_q_t got, input byte_q_t want);
    check({tag, "_len"}, got.size(), want.size());
    for (int i = 0; i < want.size() && i < got.size(); i++)
      check($sformatf("%s_%0d", tag, i), got[i], want[i]);
  endtask

  task automatic tick();
    @(posedge i_Clk); #1;
  endtask

  task automatic pulse_start(input logic [7:0] cmd, input logic [5:0] len, input logic rd);
    i_Cmd = cmd; i_Len = len; i_Rd = rd; i_Start = 1'b1;
    tick();
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    check({tag, "_done_seen"}, done_cnt >= target, 1'b1);
  endtask

  task automatic clear_logs();
    mosi_q.delete(); rx_q.delete(); slave_q.delete(); exp_q.delete();
  endtask

  // Transceiver model: one byte takes 20 clocks, aborted by system reset.
  initial begin
    logic aborted;
    m_ready = 1'b1; m_rx_dv = 1'b0; m_rx_byte = 8'h00;
    forever begin
      tick();
      if (o_M_TX_DV === 1'b1) begin
        check("dv_while_ready", m_ready, 1'b1);
        mosi_q.push_back(o_M_TX_Byte);
        m_ready = 1'b0;
        aborted = 1'b0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (i_Rst) aborted = 1'b1;
        end
        if (!aborted) begin
          m_rx_byte = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
          m_rx_dv = 1'b1;
          tick();
          m_rx_dv = 1'b0;
        end
        m_ready = 1'b1;
      end
    end
  end

  // Payload stream source: pops a byte after each accepted handshake.
  initial begin
    logic hs;
    i_TX_Valid = 1'b0; i_TX_Data = 8'h00;
    forever begin
      @(negedge i_Clk);
      hs = o_TX_Ready && i_TX_Valid;
      tick();
      if (hs && tx_q.size() > 0) void'(tx_q.pop_front());
      i_TX_Valid = (tx_q.size() > 0) && !tx_stall;
      i_TX_Data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    end
  end

  // Output monitor: RX log, done/abort counts, CS gap and setup timing.
  initial begin
    forever begin
      tick();
      if (o_RX_Valid === 1'b1) rx_q.push_back(o_RX_Data);
      if (o_Done === 1'b1) begin
        done_cnt++;
        if (o_Abort === 1'b1) abort_cnt++;
        done_cs = o_SPI_CS_n;
        gap_arm = 1'b1;
      end
      if (o_SPI_CS_n === 1'b1) begin
        hi_streak++;
        lo_streak  = 0;
        setup_open = 1'b0;
      end else if (o_SPI_CS_n === 1'b0) begin
        if (hi_streak > 0) begin
          if (gap_arm && hi_streak < min_gap) min_gap = hi_streak;
          gap_arm    = 1'b0;
          setup_open = 1'b1;
        end
        hi_streak = 0;
        lo_streak++;
      end
      if (o_M_TX_DV === 1'b1) begin
        if (o_SPI_CS_n !== 1'b0) dv_cs_bad++;
        if (setup_open) begin
          if (lo_streak - 1 < min_setup) min_setup = lo_streak - 1;
          setup_open = 1'b0;
        end
      end
    end
  end

  initial begin
    int base, stall_bad;
    i_Rst = 1'b1; i_Start = 1'b0; i_Cmd = 8'h00; i_Len = 6'd0; i_Rd = 1'b0;
    repeat (3) tick();
    i_Rst = 1'b0;
    tick();

    // Reset state
    check("rst_cs_n", o_SPI_CS_n, 1'b1);
    check("rst_busy", o_Busy, 1'b0);
    check("rst_status", o_Status, 8'h00);
    check("rst_rx_data", o_RX_Data, 8'h00);
    check("rst_m_tx_byte", o_M_TX_Byte, 8'h00);
    check("rst_pulses", {o_Done, o_RX_Valid, o_M_TX_DV, o_Abort}, 4'b0000);

    // Write: cmd 20, payload A1 A2 A3
    clear_logs();
    tx_q = '{8'hA1, 8'hA2, 8'hA3};
    pulse_start(8'h20, 6'd3, 1'b0);
    check("wr_busy", o_Busy, 1'b1);
    wait_done("wr", 1, 1000);
    exp_q = '{8'h20, 8'hA1, 8'hA2, 8'hA3};
    check_q("wr_mosi", mosi_q, exp_q);
    check("wr_done_once", done_cnt, 1);
    check("wr_abort", abort_cnt, 0);
    check("wr_rx_count", rx_q.size(), 4);
    check("wr_tx_consumed", tx_q.size(), 0);
    check("wr_cs_at_done", done_cs, 1'b1);

    // Read: cmd 61, 5 bytes; TX stream must not be consumed
    repeat (20) tick();
    clear_logs();
    tx_q = '{8'h55};
    slave_q = '{8'h0E, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    pulse_start(8'h61, 6'd5, 1'b1);
    wait_done("rd", 2, 1000);
    exp_q = '{8'h61, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_q("rd_mosi", mosi_q, exp_q);
    exp_q = '{8'h0E, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    check_q("rd_rx", rx_q, exp_q);
    check("rd_status", o_Status, 8'h0E);
    check("rd_tx_untouched", tx_q.size(), 1);
    tx_q.delete();

    // Command only
    repeat (20) tick();
    clear_logs();
    slave_q = '{8'h3C};
    pulse_start(8'hFF, 6'd0, 1'b0);
    wait_done("len0", 3, 500);
    check("len0_bytes", mosi_q.size(), 1);
    check("len0_status", o_Status, 8'h3C);

    // Length above MAX_PAYLOAD clamps to 32 payload bytes
    repeat (20) tick();
    clear_logs();
    for (int i = 0; i < 40; i++) tx_q.push_back(8'(i + 8'h40));
    pulse_start(8'hA0, 6'd40, 1'b0);
    wait_done("len40", 4, 3000);
    check("len40_bytes", mosi_q.size(), 33);
    check("len40_last", mosi_q.size() == 33 ? mosi_q[32] : 8'h00, 8'h5F);
    check("len40_rx", rx_q.size(), 33);
    check("len40_tx_left", tx_q.size(), 8);
    tx_q.delete();

    // Payload stall of 200 clocks after the first payload byte
    repeat (20) tick();
    clear_logs();
    tx_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
    pulse_start(8'hC0, 6'd4, 1'b0);
    for (int i = 0; i < 500 && mosi_q.size() < 2; i++) tick();
    tx_stall = 1'b1;
    repeat (30) tick();
    stall_bad = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (mosi_q.size() != 2 || o_SPI_CS_n !== 1'b0 || o_M_TX_DV !== 1'b0) stall_bad++;
    end
    check("stall_quiet", stall_bad, 0);
    tx_stall = 1'b0;
    wait_done("stall", 5, 1000);
    exp_q = '{8'hC0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    check_q("stall_mosi", mosi_q, exp_q);
    check("stall_abort", abort_cnt, 0);

    // Start pulse while busy is ignored and not queued
    repeat (20) tick();
    clear_logs();
    tx_q = '{8'hD1};
    pulse_start(8'h10, 6'd1, 1'b0);
    for (int i = 0; i < 200 && mosi_q.size() < 1; i++) tick();
    pulse_start(8'h77, 6'd2, 1'b1);
    wait_done("busy", 6, 1000);
    repeat (40) tick();
    exp_q = '{8'h10, 8'hD1};
    check_q("busy_mosi", mosi_q, exp_q);
    check("busy_no_queue", done_cnt, 6);
    check("busy_idle", o_Busy, 1'b0);

    // Start held high: back-to-back transactions honour the idle gap
    clear_logs();
    i_Cmd = 8'h05; i_Len = 6'd0; i_Rd = 1'b0; i_Start = 1'b1;
    for (int i = 0; i < 500 && done_cnt < 7; i++) tick();
    for (int i = 0; i < 100 && o_Busy !== 1'b0; i++) tick();
    for (int i = 0; i < 100 && o_Busy !== 1'b1; i++) tick();
    i_Start = 1'b0;
    wait_done("b2b", 8, 500);
    repeat (40) tick();
    check("b2b_done_cnt", done_cnt, 8);
    exp_q = '{8'h05, 8'h05};
    check_q("b2b_mosi", mosi_q, exp_q);
    check("gap_min_ok", min_gap >= 8, 1'b1);
    check("setup_min_ok", min_setup >= 4, 1'b1);
    check("dv_with_cs_low", dv_cs_bad, 0);

    // Reset during the second byte
    clear_logs();
    tx_q = '{8'hE1, 8'hE2, 8'hE3};
    pulse_start(8'h20, 6'd3, 1'b0);
    for (int i = 0; i < 500 && mosi_q.size() < 2; i++) tick();
    base = done_cnt;
    i_Rst = 1'b1;
    tick();
    check("mrst_cs_n", o_SPI_CS_n, 1'b1);
    check("mrst_busy", o_Busy, 1'b0);
    check("mrst_outs", {o_Status, o_RX_Data, o_M_TX_Byte}, 24'h0);
    i_Rst = 1'b0;
    repeat (40) tick();
    check("mrst_no_done", done_cnt, base);
    check("mrst_cs_stays_high", o_SPI_CS_n, 1'b1);
    tx_q.delete();

`ifdef SPI_SEQ_TIMEOUT_EN
    // Payload never arrives: timeout aborts with CS released
    repeat (20) tick();
    clear_logs();
    base = done_cnt;
    tx_stall = 1'b1;
    tx_q = '{8'hF1, 8'hF2};
    pulse_start(8'h30, 6'd2, 1'b0);
    wait_done("timeout", base + 1, 2000);
    check("timeout_abort", abort_cnt, 1);
    check("timeout_cs_high", done_cs, 1'b1);
    check("timeout_bytes", mosi_q.size(), 1);
    tx_stall = 1'b0;
    tx_q.delete();
    repeat (20) tick();
`else
    check("abort_never", abort_cnt, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
